// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// ALU operation codes, exception causes, FSM states and the control-word layout.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_PASS = 4'b0111;  // pass operand B through the ALU

  localparam logic [4:0] CAUSE_NONE = 5'd0;
  localparam logic [4:0] CAUSE_RI   = 5'd10;
  localparam logic [4:0] CAUSE_OV   = 5'd12;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
`ifdef MULTICYCLE_CTRL_EXC_EN
   ,S_EXCEPT    = 4'd11
`endif
  } state_t;

  // Registered part of the control word; pc_en here excludes the
  // mem_ready / alu_zero gated terms, which are added combinationally.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] aluctrl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       epc_write;
    logic       cause_write;
    logic [4:0] cause_code;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// R-type funct decoder: ALU operation, legality, and whether signed overflow
// on this operation must trap.
module alu_ctrl_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluctrl,
  output logic       legal,
  output logic       trap_on_ovf
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    aluctrl     = ALU_ADD;
    legal       = 1'b1;
    trap_on_ovf = 1'b0;
    case (funct)
      FN_ADD:  trap_on_ovf = 1'b1;
      FN_ADDU: aluctrl = ALU_ADD;
      FN_SUB: begin
        aluctrl     = ALU_SUB;
        trap_on_ovf = 1'b1;
      end
      FN_SUBU: aluctrl = ALU_SUB;
      FN_AND:  aluctrl = ALU_AND;
      FN_OR:   aluctrl = ALU_OR;
      FN_NOR:  aluctrl = ALU_NOR;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core. Define MULTICYCLE_CTRL_EXC_EN
// to add precise exceptions for signed overflow and reserved instructions.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RESET_TO_FETCH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] aluctrl,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       epc_write,
  output logic       cause_write,
  output logic [4:0] cause_code
);

  localparam logic [3:0] RST_LAST = 4'(RESET_TO_FETCH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] rst_cnt_q, rst_cnt_d;
  ctrl_t      ctrl_q, ctrl_d;

  logic [3:0] dec_aluctrl;
  logic       dec_legal;
  logic       dec_trap;

  alu_ctrl_dec u_alu_ctrl_dec (
    .funct       (funct),
    .aluctrl     (dec_aluctrl),
    .legal       (dec_legal),
    .trap_on_ovf (dec_trap)
  );

`ifdef MULTICYCLE_CTRL_EXC_EN
  logic [4:0] cause_d;
`else
  logic unused_exc;
  assign unused_exc = ^{alu_ovf, dec_trap};
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
`ifdef MULTICYCLE_CTRL_EXC_EN
    cause_d   = CAUSE_NONE;
`endif
    case (state_q)
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) state_d   = S_FETCH;
        else                       rst_cnt_d = rst_cnt_q + 4'd1;
      end
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
`ifdef MULTICYCLE_CTRL_EXC_EN
            state_d = S_EXCEPT;
            cause_d = CAUSE_RI;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: begin
        if (!dec_legal) begin
`ifdef MULTICYCLE_CTRL_EXC_EN
          state_d = S_EXCEPT;
          cause_d = CAUSE_RI;
`else
          state_d = S_FETCH;
`endif
        end
`ifdef MULTICYCLE_CTRL_EXC_EN
        else if (dec_trap && alu_ovf) begin
          state_d = S_EXCEPT;
          cause_d = CAUSE_OV;
        end
`endif
        else state_d = S_R_WB;
      end
      default: state_d = S_FETCH;  // MEM_WB, R_WB, BRANCH, JUMP, EXCEPT
    endcase

    // Control word for the state being entered, so outputs leave a flop.
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.aluctrl   = ALU_ADD;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = SRCB_IMM_SH2;
        ctrl_d.aluctrl   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.aluctrl   = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_B;
        ctrl_d.aluctrl   = dec_aluctrl;
      end
      S_R_WB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_B;
        ctrl_d.aluctrl   = ALU_SUB;
        ctrl_d.pc_source = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_d.pc_source = PC_JUMP;
        ctrl_d.pc_en     = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_EXC_EN
      S_EXCEPT: begin
        ctrl_d.epc_write   = 1'b1;
        ctrl_d.cause_write = 1'b1;
        ctrl_d.cause_code  = cause_d;
        ctrl_d.pc_source   = PC_EXC;
        ctrl_d.pc_en       = 1'b1;
      end
`endif
      default: ctrl_d = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an async reset, so every
  // flop updates from pre-edge values and reset clears outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      rst_cnt_q <= 4'd0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // IR and PC loads in FETCH, and the taken branch, depend on same-cycle inputs.
  assign ir_write    = (state_q == S_FETCH) && mem_ready;
  assign pc_en       = ctrl_q.pc_en
                     | ((state_q == S_FETCH)  && mem_ready)
                     | ((state_q == S_BRANCH) && alu_zero);

  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign iord        = ctrl_q.iord;
  assign pc_source   = ctrl_q.pc_source;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign aluctrl     = ctrl_q.aluctrl;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign epc_write   = ctrl_q.epc_write;
  assign cause_write = ctrl_q.cause_write;
  assign cause_code  = ctrl_q.cause_code;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; covers both builds of
// MULTICYCLE_CTRL_EXC_EN. Inputs change at the falling edge, outputs are checked 1ns later.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int unsigned RTF = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, alu_ovf, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_source, alu_src_b;
  logic       alu_src_a;
  logic [3:0] aluctrl;
  logic       reg_dst, mem_to_reg, reg_write, epc_write, cause_write;
  logic [4:0] cause_code;

  int n_pass  = 0;
  int n_total = 0;
  int rd_cycles, wr_pulses;

  multicycle_ctrl #(.RESET_TO_FETCH_CYCLES(RTF)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluctrl(aluctrl),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .epc_write(epc_write), .cause_write(cause_write), .cause_code(cause_code)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] all_outs();
    return 32'({mem_read, mem_write, iord, ir_write, pc_en, pc_source, alu_src_a,
                alu_src_b, aluctrl, reg_dst, mem_to_reg, reg_write, epc_write,
                cause_write, cause_code});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    check(tag, 32'(dut.state_q), 32'(exp));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Starts in FETCH, ends one cycle later in DECODE.
  task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn; mem_ready = 1'b1;
    #1;
    chk_state("fetch_state", S_FETCH);
    check("fetch_ir_write", 32'(ir_write), 1);
    check("fetch_pc_en", 32'(pc_en), 1);
    check("fetch_mem_read", 32'(mem_read), 1);
    cyc(); mem_ready = 1'b0; #1;
    chk_state("decode_state", S_DECODE);
    check("decode_srcb", 32'(alu_src_b), 32'(2'b11));
    check("decode_aluctrl", 32'(aluctrl), 32'(4'b0010));
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [3:0] exp_alu,
                           input logic ovf, input logic exp_wb);
    do_fetch(OP_RTYPE, fn);
    cyc(); alu_ovf = ovf; #1;
    chk_state("exec_state", S_EXECUTE);
    check("exec_aluctrl", 32'(aluctrl), 32'(exp_alu));
    check("exec_src", 32'({alu_src_a, alu_src_b}), 32'(3'b100));
    check("exec_no_write", 32'(reg_write), 0);
    cyc(); alu_ovf = 1'b0; #1;
    if (exp_wb) begin
      chk_state("rwb_state", S_R_WB);
      check("rwb_ctrl", 32'({reg_write, reg_dst, mem_to_reg}), 32'(3'b110));
      cyc(); #1;
    end
    chk_state("rtype_back_fetch", S_FETCH);
    check("rtype_fetch_no_write", 32'(reg_write | mem_write), 0);
  endtask

`ifdef MULTICYCLE_CTRL_EXC_EN
  task automatic run_except(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                            input logic via_exec, input logic [4:0] exp_cause);
    do_fetch(op, fn);
    if (via_exec) begin
      cyc(); alu_ovf = ovf; #1;
      chk_state("exc_exec_state", S_EXECUTE);
    end
    cyc(); alu_ovf = 1'b0; #1;
    chk_state("exc_state", S_EXCEPT);
    check("exc_cause", 32'(cause_code), 32'(exp_cause));
    check("exc_epc_cause_write", 32'({epc_write, cause_write}), 32'(2'b11));
    check("exc_pc", 32'({pc_en, pc_source}), 32'(3'b111));
    check("exc_no_reg_write", 32'(reg_write), 0);
    cyc(); #1;
    chk_state("exc_back_fetch", S_FETCH);
    check("exc_cause_cleared", 32'({epc_write, cause_write, cause_code}), 0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0;
    alu_zero = 1'b0; alu_ovf = 1'b0; mem_ready = 1'b0;

    // Reset and the RESET -> FETCH delay
    repeat (2) cyc();
    #1;
    check("reset_outputs", all_outs(), 0);
    chk_state("reset_state", S_RESET);
    cyc(); rst_n = 1'b1;
    cyc(); #1;
    chk_state("rtf_still_reset", S_RESET);
    check("rtf_outputs_zero", all_outs(), 0);
    cyc(); #1;
    chk_state("rtf_fetch", S_FETCH);
    check("fetch_wait_ctrl", 32'({mem_read, iord, alu_src_a, alu_src_b, aluctrl, pc_source}),
          32'({1'b1, 1'b0, 1'b0, 2'b01, 4'b0010, 2'b00}));
    check("fetch_wait_no_load", 32'({ir_write, pc_en}), 0);
    cyc(); #1;
    chk_state("fetch_hold", S_FETCH);

    // R-type operations
    run_rtype(FN_ADD,  4'b0010, 1'b0, 1'b1);
    run_rtype(FN_SUB,  4'b0110, 1'b0, 1'b1);
    run_rtype(FN_SUBU, 4'b0110, 1'b0, 1'b1);
    run_rtype(FN_AND,  4'b0000, 1'b0, 1'b1);
    run_rtype(FN_OR,   4'b0001, 1'b0, 1'b1);
    run_rtype(FN_NOR,  4'b1100, 1'b0, 1'b1);
    run_rtype(FN_ADDU, 4'b0010, 1'b1, 1'b1);

    // lw with three wait cycles in MEM_READ
    do_fetch(OP_LW, 6'd0);
    cyc(); #1;
    chk_state("lw_memaddr", S_MEM_ADDR);
    check("lw_addr_ctrl", 32'({alu_src_a, alu_src_b, aluctrl}), 32'({1'b1, 2'b10, 4'b0010}));
    rd_cycles = 0; wr_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); mem_ready = (i == 3); #1;
      chk_state("lw_memread", S_MEM_READ);
      if (mem_read && iord) rd_cycles++;
      if (reg_write) wr_pulses++;
    end
    check("lw_read_held", 32'(rd_cycles), 4);
    cyc(); mem_ready = 1'b0; #1;
    chk_state("lw_memwb", S_MEM_WB);
    check("lw_wb_ctrl", 32'({reg_write, mem_to_reg, reg_dst, mem_read}), 32'(4'b1100));
    if (reg_write) wr_pulses++;
    cyc(); #1;
    chk_state("lw_back_fetch", S_FETCH);
    if (reg_write) wr_pulses++;
    check("lw_single_write", 32'(wr_pulses), 1);

    // sw: mem_ready in MEM_ADDR is ignored, one wait cycle in MEM_WRITE
    do_fetch(OP_SW, 6'd0);
    cyc(); mem_ready = 1'b1; #1;
    chk_state("sw_memaddr", S_MEM_ADDR);
    cyc(); mem_ready = 1'b0; #1;
    chk_state("sw_memwrite_wait", S_MEM_WRITE);
    check("sw_strobe", 32'({mem_write, iord, mem_read}), 32'(3'b110));
    cyc(); mem_ready = 1'b1; #1;
    chk_state("sw_memwrite_done", S_MEM_WRITE);
    check("sw_strobe_held", 32'(mem_write), 1);
    cyc(); mem_ready = 1'b0; #1;
    chk_state("sw_back_fetch", S_FETCH);
    check("sw_strobe_dropped", 32'(mem_write), 0);

    // beq taken and not taken
    do_fetch(OP_BEQ, 6'd0);
    cyc(); alu_zero = 1'b1; #1;
    chk_state("beq_state", S_BRANCH);
    check("beq_taken", 32'({pc_en, pc_source, aluctrl}), 32'({1'b1, 2'b01, 4'b0110}));
    alu_zero = 1'b0; #1;
    check("beq_not_taken", 32'({pc_en, aluctrl}), 32'({1'b0, 4'b0110}));
    cyc(); #1;
    chk_state("beq_back_fetch", S_FETCH);

    // j
    do_fetch(OP_J, 6'd0);
    cyc(); #1;
    chk_state("j_state", S_JUMP);
    check("j_pc", 32'({pc_en, pc_source}), 32'(3'b110));
    cyc(); #1;
    chk_state("j_back_fetch", S_FETCH);

`ifdef MULTICYCLE_CTRL_EXC_EN
    run_except(OP_RTYPE, FN_ADD, 1'b1, 1'b1, 5'd12);
    run_except(OP_RTYPE, FN_SUB, 1'b1, 1'b1, 5'd12);
    run_except(6'b111111, 6'd0, 1'b0, 1'b0, 5'd10);
    run_except(OP_RTYPE, 6'b111111, 1'b0, 1'b1, 5'd10);
`else
    run_rtype(FN_ADD, 4'b0010, 1'b1, 1'b1);
    run_rtype(6'b111111, 4'b0010, 1'b0, 1'b0);
    do_fetch(6'b111111, 6'd0);
    cyc(); #1;
    chk_state("illegal_op_nop", S_FETCH);
    check("illegal_op_no_strobes", 32'({reg_write, mem_write, epc_write, cause_write}), 0);
`endif

    // Reset asserted during a MEM_READ wait
    do_fetch(OP_LW, 6'd0);
    cyc(); #1;
    cyc(); mem_ready = 1'b0; #1;
    chk_state("rst_pre_memread", S_MEM_READ);
    check("rst_pre_strobe", 32'(mem_read), 1);
    #1; rst_n = 1'b0; #1;
    check("rst_async_outputs", all_outs(), 0);
    chk_state("rst_async_state", S_RESET);
    cyc(); cyc(); rst_n = 1'b1;
    cyc(); #1;
    chk_state("rst_release_wait", S_RESET);
    cyc(); #1;
    chk_state("rst_release_fetch", S_FETCH);
    check("rst_fetch_strobe", 32'(mem_read), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
